// File: rtl/aes_inv_key_sched_pkg.sv
// Shared AES constants and helpers for the inverse key-schedule walker.
package aes_inv_key_sched_pkg;

  localparam logic [1:0] LEN_128 = 2'b00;
  localparam logic [1:0] LEN_192 = 2'b01;
  localparam logic [1:0] LEN_256 = 2'b10;
  localparam logic [1:0] LEN_BAD = 2'b11;

  localparam logic [7:0] RCON_START_128 = 8'h36;
  localparam logic [7:0] RCON_START_192 = 8'h80;
  localparam logic [7:0] RCON_START_256 = 8'h40;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      LEN_192: return 4'd6;
      LEN_256: return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      LEN_192: return 4'd12;
      LEN_256: return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] rcon_start(input logic [1:0] len);
    case (len)
      LEN_192: return RCON_START_192;
      LEN_256: return RCON_START_256;
      default: return RCON_START_128;
    endcase
  endfunction

  // Inverse of GF(2^8) doubling: steps the round constant backwards.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a sits at bit 2047-8a, which is {~a, 3'b111}.
  assign s = TABLE[{~a, 3'b111} -: 8];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse AES key-schedule walker: regenerates round keys Nr..0 from the last
// Nk expanded-key words. Optional macro AES_INV_KS_ZEROIZE_EN clears key
// material on completion and forces rk_out to 0 while rk_valid is low.
module aes_inv_key_sched
  import aes_inv_key_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kld,
  input  logic [1:0]   len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         done
);

  state_t      state, state_nxt;
  logic [31:0] win [8];   // win[k] holds w[idx+k]
  logic [5:0]  idx;
  logic [3:0]  out_rnd;
  logic [2:0]  nkm1;
  logic [2:0]  jpos;      // (idx-1+Nk) mod Nk; always 3 at load for every key length
  logic [7:0]  rcon;

  logic        load, run, stall, step, avail, accept, final_acc;
  logic [6:0]  top_idx, last_needed;
  logic [2:0]  off;
  logic [31:0] x, top, sub_in, sub_out, g, new_w;
  logic [127:0] rk_sel;

  assign load        = kld && (len != LEN_BAD);
  assign run         = (state == RUN);
  assign top_idx     = {1'b0, idx} + {4'b0, nkm1};
  assign last_needed = {1'b0, out_rnd, 2'b11};
  assign stall       = (top_idx <= last_needed);
  assign step        = run && (idx != 6'd0) && !stall;
  assign avail       = run && ({out_rnd, 2'b00} >= idx);
  assign accept      = avail && rk_ready;
  assign final_acc   = accept && (out_rnd == 4'd0);
  assign off         = 3'({out_rnd, 2'b00} - idx);

  // Next backward word: w[idx-1] = w[j] ^ g(w[j-1]) with j = idx-1+Nk.
  always_comb begin
    x      = win[nkm1 - 3'd1];
    top    = win[nkm1];
    sub_in = (jpos == 3'd0) ? rot_word(x) : x;
    if (jpos == 3'd0)                          g = sub_out ^ {rcon, 24'h0};
    else if ((nkm1 == 3'd7) && (jpos == 3'd4)) g = sub_out;
    else                                       g = x;
    new_w  = top ^ g;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .s(sub_out[8*b +: 8]));
  end

  // Round-key window select.
  always_comb begin
    rk_sel = {win[off], win[off + 3'd1], win[off + 3'd2], win[off + 3'd3]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: a legal load always (re)starts, final accept ends the walk.
  always_comb begin
    state_nxt = state;
    if (load)           state_nxt = RUN;
    else if (final_acc) state_nxt = IDLE;
  end

  // Window, index, round counter, rcon and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win     <= '{default: '0};
      idx     <= '0;
      out_rnd <= '0;
      nkm1    <= '0;
      jpos    <= '0;
      rcon    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        for (int unsigned k = 0; k < 8; k++) win[k] <= key_in[255 - 32*k -: 32];
        idx     <= 6'({nr_of(len), 2'b00} + 6'd4 - {2'b00, nk_of(len)});
        out_rnd <= nr_of(len);
        nkm1    <= 3'(nk_of(len) - 4'd1);
        jpos    <= 3'd3;
        rcon    <= rcon_start(len);
      end else if (run) begin
        if (step) begin
          for (int unsigned k = 7; k > 0; k--) win[k] <= win[k-1];
          win[0] <= new_w;
          idx    <= idx - 6'd1;
          jpos   <= (jpos == 3'd0) ? nkm1 : jpos - 3'd1;
          if (jpos == 3'd0) rcon <= inv_xtime(rcon);
        end
        if (accept && (out_rnd != 4'd0)) out_rnd <= out_rnd - 4'd1;
        if (final_acc) begin
          done <= 1'b1;
`ifdef AES_INV_KS_ZEROIZE_EN
          win  <= '{default: '0};
          rcon <= '0;
`endif
        end
      end
    end
  end

  assign busy     = run;
  assign rk_valid = avail;
  assign rk_round = out_rnd;
  assign rk_last  = avail && (out_rnd == 4'd0);
`ifdef AES_INV_KS_ZEROIZE_EN
  assign rk_out   = avail ? rk_sel : '0;
`else
  assign rk_out   = rk_sel;
`endif

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched: expected round keys come from a
// forward FIPS-197 key expansion computed inside the bench.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         kld = 1'b0;
  logic [1:0]   len = 2'b00;
  logic [255:0] key_in = '0;
  logic         busy, rk_valid, rk_last, done;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;

  aes_inv_key_sched dut (
    .clk(clk), .rst_n(rst_n), .kld(kld), .len(len), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
    .rk_round(rk_round), .rk_last(rk_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    logic         last;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic        expect_done = 1'b0;
  logic [7:0]  sbox_t [256];
  logic [31:0] ew [60];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[a] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  // Forward expansion of a cipher key into ew[0..4Nr+3].
  task automatic expand(input int nk, input logic [255:0] ck);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          nr = nk + 6;
    for (int i = 0; i < nk; i++) ew[i] = ck[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = ew[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      ew[i] = ew[i-nk] ^ t;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expand, queue expected keys Nr..0, pulse kld with the last Nk words.
  task automatic start_load(input int l, input logic [255:0] ck);
    int nk = (l == 0) ? 4 : (l == 1) ? 6 : 8;
    int nr = nk + 6;
    int base = 4*(nr+1) - nk;
    logic [255:0] k = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
    expand(nk, ck);
    sb.delete();
    expect_done = 1'b0;
    for (int r = nr; r >= 0; r--)
      sb.push_back('{rnd: 4'(r), key: {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]},
                     last: (r == 0)});
    for (int i = 0; i < nk; i++) k[255 - 32*i -: 32] = ew[base + i];
    kld = 1'b1;
    len = 2'(l);
    key_in = k;
    tick();
    kld = 1'b0;
  endtask

  // Drain the walk with a given rk_ready probability; optional illegal kld at cycle junk_at.
  task automatic drain(input int pct, input int junk_at);
    int cyc = 0;
    while ((sb.size() != 0 || expect_done) && cyc < 3000) begin
      rk_ready = ($urandom_range(99) < pct);
      if (cyc == junk_at) begin
        kld = 1'b1;
        len = 2'b11;
        key_in = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      end else begin
        kld = 1'b0;
      end
      tick();
      cyc++;
    end
    kld = 1'b0;
    rk_ready = 1'b1;
    if (cyc >= 3000) chk("drain_timeout", 1, 0);
    chk("idle_busy", busy, 0);
`ifdef AES_INV_KS_ZEROIZE_EN
    chk("zeroize_rk_out", rk_out, 0);
`endif
  endtask

  // Monitor: compares presented keys to the queue front, pops on handshake.
  always @(negedge clk) begin
    if (rst_n && !(kld && len != 2'b11)) begin
      if (expect_done) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        expect_done = 1'b0;
      end else if (done) begin
        chk("done_spurious", done, 0);
      end
      if (rk_valid) begin
        if (sb.size() == 0) begin
          chk("extra_key_valid", rk_valid, 0);
        end else begin
          chk("rk_round", rk_round, sb[0].rnd);
          chk("rk_out", rk_out, sb[0].key);
          chk("rk_last", rk_last, sb[0].last);
          if (rk_ready) begin
            if (sb[0].last) expect_done = 1'b1;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0] rk;
    int cyc;
    build_sbox();
    rk_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", rk_valid, 0);
    chk("rst_last", rk_last, 0);
    chk("rst_done", done, 0);
    chk("rst_round", rk_round, 0);
    chk("rst_rk_out", rk_out, 0);
    rst_n = 1'b1;
    tick();

    // Illegal length in IDLE is ignored.
    kld = 1'b1; len = 2'b11; key_in = {8{32'hdeadbeef}};
    tick();
    kld = 1'b0;
    chk("illegal_busy", busy, 0);
    chk("illegal_valid", rk_valid, 0);

    // FIPS-197 keys, full throughput then heavy backpressure.
    start_load(0, KEY128); drain(100, -1);
    start_load(1, KEY192); drain(100, -1);
    start_load(2, KEY256); drain(100, -1);
    start_load(0, KEY128); drain(30, -1);
    start_load(1, KEY192); drain(30, 7);
    start_load(2, KEY256); drain(30, -1);

    // Random keys and lengths, with an illegal kld mid-run.
    for (int t = 0; t < 6; t++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      start_load(t % 3, rk);
      drain($urandom_range(20, 100), $urandom_range(2, 20));
    end

    // Legal reload at round 5 restarts at round 10 of the new key.
    start_load(0, KEY128);
    cyc = 0;
    while (!(rk_valid && rk_round == 4'd5) && cyc < 500) begin
      rk_ready = 1'b1;
      tick();
      cyc++;
    end
    chk("abort_reach_r5", rk_round, 5);
    rk = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    start_load(0, rk);
    chk("abort_valid", rk_valid, 1);
    chk("abort_round", rk_round, 10);
    drain(100, -1);

    // Reset mid AES-256 walk aborts without a done pulse.
    start_load(2, KEY256);
    for (int i = 0; i < 10; i++) begin
      rk_ready = $urandom_range(1);
      tick();
    end
    rst_n = 1'b0;
    sb.delete();
    expect_done = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", rk_valid, 0);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("postrst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
